// File: rtl/latch_wr_pkg.sv
// -----------------------------------------------------------------------------
// latch_wr_pkg
// Shared definitions for the latch write controller:
//   - state_e    : sequencer states (IDLE, SETUP, OPEN, HOLD)
//   - CNT_W      : width of the phase down-counter
//   - cnt_load() : counter preload for a phase lasting N cycles
//   - params_ok(): elaboration-time range check of the controller parameters
// -----------------------------------------------------------------------------
package latch_wr_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_OPEN  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // A phase of N cycles exits when the counter reaches 0, so it starts at N-1.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

    function automatic bit params_ok(input int unsigned dw,
                                     input int unsigned depth,
                                     input int unsigned aw,
                                     input int unsigned t_s,
                                     input int unsigned t_o,
                                     input int unsigned t_h);
        return (dw >= 1) && (depth >= 2) && (depth <= 16) &&
               (aw >= $clog2(depth)) && (aw <= 31) &&
               (t_s >= 1) && (t_s <= 15) &&
               (t_o >= 1) && (t_o <= 15) &&
               (t_h >= 1) && (t_h <= 15);
    endfunction

endpackage

// File: rtl/latch_wr_ctrl_if.sv
// -----------------------------------------------------------------------------
// latch_wr_ctrl_if
// Request handshake and latch-array bus of the latch write controller.
//   req_valid/req_ready/req_addr/req_data : write request (master -> ctrl)
//   lat_d   : shared D bus to the latch array
//   lat_en  : one-hot, transparent-high latch enables
//   busy    : write sequence in progress or pending
//   err     : one-cycle pulse, out-of-range request dropped
// master = request source / latch array side, slave = controller.
// -----------------------------------------------------------------------------
interface latch_wr_ctrl_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
);
    logic             req_valid;
    logic             req_ready;
    logic [AW-1:0]    req_addr;
    logic [DW-1:0]    req_data;
    logic [DW-1:0]    lat_d;
    logic [DEPTH-1:0] lat_en;
    logic             busy;
    logic             err;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, lat_d, lat_en, busy, err
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, lat_d, lat_en, busy, err
    );
endinterface

// File: rtl/latch_wr_slot.sv
// -----------------------------------------------------------------------------
// latch_wr_slot
// One-entry pending request register with a registered ready.
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   push_valid_i/_ready_o: producer handshake (ready = slot empty, registered)
//   push_data_i          : entry written on an accepted push
//   pop_i                : consumer frees the slot this edge
//   full_o, data_o       : slot occupancy and stored entry
// -----------------------------------------------------------------------------
module latch_wr_slot #(
    parameter int unsigned W = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_valid_i,
    output logic         push_ready_o,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic [W-1:0] data_o
);
    logic         full_q, full_d;
    logic         ready_q;
    logic [W-1:0] data_q, data_d;
    logic         push;

    assign push = push_valid_i && ready_q;

    // Pop is applied before push so a same-edge pop+push leaves the slot full.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (push) begin
            full_d = 1'b1;
            data_d = push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q  <= 1'b0;
            ready_q <= 1'b1;
            data_q  <= '0;
        end else begin
            full_q  <= full_d;
            ready_q <= !full_d;
            data_q  <= data_d;
        end
    end

    assign push_ready_o = ready_q;
    assign full_o       = full_q;
    assign data_o       = data_q;
endmodule

// File: rtl/latch_wr_ctrl.sv
// -----------------------------------------------------------------------------
// latch_wr_ctrl
// Sequences writes into an external array of transparent-high latches:
// D bus set up for T_SETUP cycles, one enable high for T_OPEN cycles, D held
// for T_HOLD cycles. Back-to-back requests chain HOLD -> SETUP with no gap.
// Out-of-range addresses are consumed and reported with a one-cycle err.
//   CLK  : sole clock, rising edge
//   RSTB : synchronous active-low reset
//   bus  : latch_wr_ctrl_if slave (request handshake, lat_d, lat_en, busy, err)
// -----------------------------------------------------------------------------
module latch_wr_ctrl
    import latch_wr_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned AW      = 2,
    parameter int unsigned T_SETUP = 1,
    parameter int unsigned T_OPEN  = 1,
    parameter int unsigned T_HOLD  = 1
) (
    input logic            CLK,
    input logic            RSTB,
    latch_wr_ctrl_if.slave bus
);
    if (!params_ok(DW, DEPTH, AW, T_SETUP, T_OPEN, T_HOLD)) begin : g_param_chk
        $error("latch_wr_ctrl: parameter out of range");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    lat_d_q, lat_d_d;
    logic [DEPTH-1:0] lat_en_q, lat_en_d;
    logic             err_q, err_d;

    logic             slot_full, slot_pop, slot_ready;
    logic [AW+DW-1:0] slot_q;
    logic [AW-1:0]    slot_addr;
    logic [DW-1:0]    slot_data;
    logic             addr_ok;
    logic             launch;

    latch_wr_slot #(.W(AW + DW)) u_slot (
        .clk_i       (CLK),
        .rst_ni      (RSTB),
        .push_valid_i(bus.req_valid),
        .push_ready_o(slot_ready),
        .push_data_i ({bus.req_addr, bus.req_data}),
        .pop_i       (slot_pop),
        .full_o      (slot_full),
        .data_o      (slot_q)
    );

    assign slot_addr = slot_q[AW+DW-1:DW];
    assign slot_data = slot_q[DW-1:0];
    assign addr_ok   = 32'(slot_addr) < DEPTH;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        lat_d_d  = lat_d_q;
        lat_en_d = lat_en_q;
        err_d    = 1'b0;
        slot_pop = 1'b0;
        launch   = 1'b0;

        case (state_q)
            ST_IDLE: launch = 1'b1;
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d  = ST_OPEN;
                    cnt_d    = cnt_load(T_OPEN);
                    lat_en_d = DEPTH'(1) << addr_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_OPEN: begin
                if (cnt_q == '0) begin
                    state_d  = ST_HOLD;
                    cnt_d    = cnt_load(T_HOLD);
                    lat_en_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    launch  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // IDLE and the last HOLD cycle share one launch point, which is what
        // makes back-to-back writes run without an IDLE gap.
        if (launch && slot_full) begin
            slot_pop = 1'b1;
            if (addr_ok) begin
                state_d = ST_SETUP;
                cnt_d   = cnt_load(T_SETUP);
                addr_d  = slot_addr;
                lat_d_d = slot_data;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            lat_d_q  <= '0;
            lat_en_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            lat_d_q  <= lat_d_d;
            lat_en_q <= lat_en_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready = slot_ready;
    assign bus.lat_d     = lat_d_q;
    assign bus.lat_en    = lat_en_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != ST_IDLE) || slot_full;
endmodule

// File: tb/tb_latch_wr_ctrl.sv
module tb_latch_wr_ctrl;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;
    localparam int unsigned D0 = 4;
    localparam int unsigned D1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n, rst1_n;

    latch_wr_ctrl_if #(.DW(DW), .DEPTH(D0), .AW(AW)) bus0 ();
    latch_wr_ctrl_if #(.DW(DW), .DEPTH(D1), .AW(AW)) bus1 ();

    latch_wr_ctrl #(.DW(DW), .DEPTH(D0), .AW(AW),
                    .T_SETUP(1), .T_OPEN(1), .T_HOLD(1)) dut0 (
        .CLK (clk),
        .RSTB(rst0_n),
        .bus (bus0)
    );

    latch_wr_ctrl #(.DW(DW), .DEPTH(D1), .AW(AW),
                    .T_SETUP(2), .T_OPEN(3), .T_HOLD(2)) dut1 (
        .CLK (clk),
        .RSTB(rst1_n),
        .bus (bus1)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_t;

    sb_t q0[$];
    sb_t q1[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drivers act on the falling edge; acceptance is decided by the ready value
    // that will be sampled on the following rising edge.
    task automatic drive0(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus0.req_valid = v;
        bus0.req_addr  = a;
        bus0.req_data  = d;
        if (v && bus0.req_ready === 1'b1 && rst0_n) q0.push_back('{a, d});
    endtask

    task automatic drive1(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus1.req_valid = v;
        bus1.req_addr  = a;
        bus1.req_data  = d;
        if (v && bus1.req_ready === 1'b1 && rst1_n) q1.push_back('{a, d});
    endtask

    task automatic sb_pop(input int id, output sb_t e, output bit ok);
        e  = '{addr: '0, data: '0};
        ok = 1'b0;
        if (id == 0) begin
            if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
        end else begin
            if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
        end
    endtask

    logic [15:0]   en_prev  [2];
    logic [DW-1:0] d_prev   [2];
    logic          err_prev [2];
    bit            rst_prev [2];

    task automatic mon(input int id, input logic rstn, input logic [15:0] en,
                       input logic [DW-1:0] d, input logic err, input int unsigned depth);
        sb_t e;
        bit  ok;
        if (rstn && rst_prev[id]) begin
            check("lat_en_onehot0", 32'($countones(en) <= 1), 32'd1);
            if (en != '0 || en_prev[id] != '0)
                check("lat_d_stable", 32'(d), 32'(d_prev[id]));
            if (err)
                check("err_single_cycle", 32'(err_prev[id]), 32'd0);
            if (en != '0 && en_prev[id] == '0) begin
                sb_pop(id, e, ok);
                check("sb_write_expected", 32'(ok), 32'd1);
                if (ok) begin
                    check("sb_lat_en", 32'(en), 32'(16'd1 << e.addr));
                    check("sb_lat_d", 32'(d), 32'(e.data));
                end
            end
            if (err) begin
                sb_pop(id, e, ok);
                check("sb_err_expected", 32'(ok), 32'd1);
                if (ok) check("sb_err_addr_range", 32'(32'(e.addr) >= depth), 32'd1);
            end
        end
        rst_prev[id] = rstn;
        en_prev[id]  = en;
        d_prev[id]   = d;
        err_prev[id] = err;
    endtask

    always @(posedge clk) begin
        #1;
        mon(0, rst0_n, 16'(bus0.lat_en), bus0.lat_d, bus0.err, D0);
        mon(1, rst1_n, 16'(bus1.lat_en), bus1.lat_d, bus1.err, D1);
    end

    task automatic drain(input int id);
        bit done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            done = (id == 0) ? !bus0.busy : !bus1.busy;
        end
        if (id == 0) begin
            check("drain0_busy", 32'(bus0.busy), 32'd0);
            check("drain0_sb_empty", 32'(q0.size()), 32'd0);
        end else begin
            check("drain1_busy", 32'(bus1.busy), 32'd0);
            check("drain1_sb_empty", 32'(q1.size()), 32'd0);
        end
    endtask

    // Per-cycle vectors for dut0: inputs driven before an edge, outputs after it.
    typedef struct {
        logic          v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [D0-1:0] en;
        logic [DW-1:0] ld;
        logic          rdy;
        logic          bsy;
    } vec_t;

    vec_t tbl [16];
    int   acc, cyc;
    logic v;

    initial begin
        // single write addr 2, data A5
        tbl[0]  = '{1'b1, 2'd2, 8'hA5, 4'b0000, 8'h00, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 2'd0, 8'h00, 4'b0000, 8'hA5, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 2'd0, 8'h00, 4'b0100, 8'hA5, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 2'd0, 8'h00, 4'b0000, 8'hA5, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 2'd0, 8'h00, 4'b0000, 8'hA5, 1'b1, 1'b0};
        // back-to-back addr 0,1,3 with valid held high
        tbl[5]  = '{1'b1, 2'd0, 8'h11, 4'b0000, 8'hA5, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 2'd1, 8'h22, 4'b0000, 8'h11, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 2'd1, 8'h22, 4'b0001, 8'h11, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 2'd3, 8'h33, 4'b0000, 8'h11, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 2'd3, 8'h33, 4'b0000, 8'h22, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 2'd3, 8'h33, 4'b0010, 8'h22, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 2'd0, 8'h00, 4'b0000, 8'h22, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 2'd0, 8'h00, 4'b0000, 8'h33, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 2'd0, 8'h00, 4'b1000, 8'h33, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 2'd0, 8'h00, 4'b0000, 8'h33, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 2'd0, 8'h00, 4'b0000, 8'h33, 1'b1, 1'b0};

        rst0_n = 1'b0;
        rst1_n = 1'b0;
        drive0(1'b0, '0, '0);
        drive1(1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst0_lat_en", 32'(bus0.lat_en), 32'd0);
        check("rst0_lat_d", 32'(bus0.lat_d), 32'd0);
        check("rst0_err", 32'(bus0.err), 32'd0);
        check("rst0_ready", 32'(bus0.req_ready), 32'd1);
        check("rst0_busy", 32'(bus0.busy), 32'd0);
        check("rst1_lat_en", 32'(bus1.lat_en), 32'd0);
        check("rst1_ready", 32'(bus1.req_ready), 32'd1);
        check("rst1_busy", 32'(bus1.busy), 32'd0);
        @(negedge clk);
        rst0_n = 1'b1;
        rst1_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive0(tbl[i].v, tbl[i].a, tbl[i].d);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_lat_en", i), 32'(bus0.lat_en), 32'(tbl[i].en));
            check($sformatf("vec%0d_lat_d", i), 32'(bus0.lat_d), 32'(tbl[i].ld));
            check($sformatf("vec%0d_ready", i), 32'(bus0.req_ready), 32'(tbl[i].rdy));
            check($sformatf("vec%0d_busy", i), 32'(bus0.busy), 32'(tbl[i].bsy));
            check($sformatf("vec%0d_err", i), 32'(bus0.err), 32'd0);
        end

        // reset during OPEN with the slot full
        @(negedge clk); drive0(1'b1, 2'd0, 8'h44);
        @(negedge clk); drive0(1'b1, 2'd2, 8'h55);
        @(negedge clk); drive0(1'b1, 2'd2, 8'h55);
        @(negedge clk);
        check("rstopen_pre_en", 32'(bus0.lat_en), 32'b0001);
        check("rstopen_pre_ready", 32'(bus0.req_ready), 32'd0);
        drive0(1'b0, '0, '0);
        rst0_n = 1'b0;
        q0.delete();
        @(posedge clk);
        #1;
        check("rstopen_lat_en", 32'(bus0.lat_en), 32'd0);
        check("rstopen_lat_d", 32'(bus0.lat_d), 32'd0);
        check("rstopen_ready", 32'(bus0.req_ready), 32'd1);
        check("rstopen_busy", 32'(bus0.busy), 32'd0);
        @(negedge clk);
        rst0_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rstopen_discard_busy", 32'(bus0.busy), 32'd0);
        check("rstopen_discard_en", 32'(bus0.lat_en), 32'd0);

        // dut1: T_SETUP=2, T_OPEN=3, T_HOLD=2, addr 1
        @(negedge clk);
        drive1(1'b1, 2'd1, 8'h5A);
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("slow_k%0d_en", k), 32'(bus1.lat_en),
                  (k >= 3 && k <= 5) ? 32'b010 : 32'd0);
            check($sformatf("slow_k%0d_lat_d", k), 32'(bus1.lat_d),
                  (k >= 1) ? 32'h5A : 32'h00);
            check($sformatf("slow_k%0d_busy", k), 32'(bus1.busy),
                  (k < 8) ? 32'd1 : 32'd0);
            if (k == 0) begin
                @(negedge clk);
                drive1(1'b0, '0, '0);
            end
        end

        // dut1: out-of-range address (DEPTH=3, addr 3)
        @(negedge clk);
        drive1(1'b1, 2'd3, 8'hEE);
        @(posedge clk); #1;
        check("oor_e0_err", 32'(bus1.err), 32'd0);
        check("oor_e0_busy", 32'(bus1.busy), 32'd1);
        @(negedge clk);
        drive1(1'b0, '0, '0);
        @(posedge clk); #1;
        check("oor_e1_err", 32'(bus1.err), 32'd1);
        check("oor_e1_en", 32'(bus1.lat_en), 32'd0);
        check("oor_e1_busy", 32'(bus1.busy), 32'd0);
        @(posedge clk); #1;
        check("oor_e2_err", 32'(bus1.err), 32'd0);
        check("oor_e2_en", 32'(bus1.lat_en), 32'd0);
        @(negedge clk);
        drive1(1'b1, 2'd2, 8'h3C);
        @(negedge clk);
        drive1(1'b0, '0, '0);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                seen = (bus1.lat_en == 3'b100);
            end
            check("oor_next_write_seen", 32'(seen), 32'd1);
            check("oor_next_write_lat_d", 32'(bus1.lat_d), 32'h3C);
        end
        drain(1);

        // random stalls, 1000 writes on dut0
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            v = ($urandom_range(0, 3) != 0);
            if (v && bus0.req_ready === 1'b1) acc++;
            drive0(v, AW'($urandom_range(0, 3)), DW'($urandom));
        end
        check("rand0_accepted", 32'(acc), 32'd1000);
        @(negedge clk);
        drive0(1'b0, '0, '0);
        drain(0);

        // random stalls with out-of-range addresses on dut1
        acc = 0;
        cyc = 0;
        while (acc < 200 && cyc < 10000) begin
            @(negedge clk);
            cyc++;
            v = ($urandom_range(0, 2) != 0);
            if (v && bus1.req_ready === 1'b1) acc++;
            drive1(v, AW'($urandom_range(0, 3)), DW'($urandom));
        end
        check("rand1_accepted", 32'(acc), 32'd200);
        @(negedge clk);
        drive1(1'b0, '0, '0);
        drain(1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/latch_wr_ctrl.md
LATCH_WR_CTRL -- requirements
Module: latch_wr_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data width of latch word.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of downstream latch words, range 2..16.
REQ-003 SHALL have parameter AW, default 2, meaning address width, at least clog2(DEPTH).
REQ-004 SHALL have parameters T_SETUP, T_OPEN, T_HOLD, default 1 each, range 1..15, meaning cycles of data-before-enable, enable-high and data-after-enable.
REQ-005 SHALL have port CLK  input  1  sole clock, all state updated on rising edge.
REQ-006 SHALL have port RSTB  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port req_valid  input  1  write request present.
REQ-008 SHALL have port req_ready  output  1  request slot free.
REQ-009 SHALL have port req_addr  input  AW  target latch word.
REQ-010 SHALL have port req_data  input  DW  word to write.
REQ-011 SHALL have port lat_d  output  DW  shared D bus to the latch array.
REQ-012 SHALL have port lat_en  output  DEPTH  one-hot latch enables (transparent-high).
REQ-013 SHALL have port busy  output  1  write sequence in progress or pending.
REQ-014 SHALL have port err  output  1  one-cycle pulse, out-of-range address dropped.

Function
REQ-015 SHALL accept a request on any rising edge with req_valid && req_ready into a 1-entry pending slot.
REQ-016 SHALL drive req_ready = !pending_full, registered, independent of req_valid.
REQ-017 SHALL implement states IDLE, SETUP, OPEN, HOLD.
REQ-018 IDLE: pending_full -> SETUP next edge, slot popped, lat_d loaded with slot data, address latched.
REQ-019 SETUP: lat_d stable, lat_en all zero, for exactly T_SETUP cycles -> OPEN.
REQ-020 OPEN: lat_en[addr] = 1, all other bits 0, lat_d stable, for exactly T_OPEN cycles -> HOLD.
REQ-021 HOLD: lat_en all zero, lat_d stable, for exactly T_HOLD cycles -> SETUP if pending_full else IDLE.
REQ-022 SHALL keep lat_d unchanged from SETUP entry through final HOLD cycle; lat_d retains last value in IDLE.
REQ-023 SHALL use a single 4-bit down-counter loaded on each state entry; state exits when counter reaches 0.
REQ-024 Back-to-back writes: period = T_SETUP+T_OPEN+T_HOLD cycles, no IDLE gap.
REQ-025 lat_en SHALL be driven directly from flops, glitch-free, at most one bit high.
REQ-026 Request with req_addr >= DEPTH: accepted, err high the cycle after pop, no SETUP/OPEN/HOLD, state stays/returns IDLE.
REQ-027 Push and pop on same edge SHALL be allowed only when slot full and popping (slot refilled, req_ready stays 1... registered as 0 only if slot remains full).
REQ-028 busy SHALL equal (state != IDLE) || pending_full.

Reset
REQ-029 RSTB low at rising edge: state IDLE, counter 0, slot empty, lat_en 0, lat_d 0, err 0, req_ready 1, busy 0.
REQ-030 Reset mid-OPEN SHALL clear lat_en on that same edge; in-flight and pending writes discarded.
REQ-031 No output SHALL be X after the first reset edge.

Structure
REQ-032 Package latch_wr_pkg SHALL hold the state enum, counter width constant (4) and parameter range checks.
REQ-033 Pending slot SHALL be sub-module latch_wr_slot (1-entry valid/ready register, DW+AW wide).
REQ-034 Implementation SHALL be 120-400 lines RTL, no latches inferred, no derived clocks.

Verification
REQ-035 Single write addr=2 data=0xA5, defaults -> lat_d=0xA5 cycle+1, lat_en=4'b0100 cycle+2 only, idle cycle+4.
REQ-036 Three back-to-back writes addr 0,1,3 -> lat_en pulses 0001,0010,1000 spaced exactly 3 cycles, req_valid held high throughout.
REQ-037 T_SETUP=2,T_OPEN=3,T_HOLD=2, addr=1 -> lat_en[1] high exactly 3 cycles, lat_d stable 7 cycles.
REQ-038 DEPTH=3, addr=3 -> err pulse one cycle, lat_en stays 0, next valid write proceeds normally.
REQ-039 RSTB low during OPEN with slot full -> next cycle lat_en=0, lat_d=0, req_ready=1, busy=0.
REQ-040 Random valid stalls, 1000 writes -> assertions: lat_en onehot0, lat_d stable whenever any lat_en bit high and one cycle either side.
